// File: rtl/rob_commit.sv
// Reorder buffer: in-order allocation, out-of-order CDB writeback, in-order
// single-entry retirement to the regfile, and a flush on a mispredicted commit.
module rob_commit #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        alloc_valid,
  input  logic        alloc_has_rd,
  input  logic [4:0]  alloc_rd,
  input  logic        alloc_is_store,
  output logic [4:0]  alloc_id,
  output logic        rob_full,
  output logic        rf_se,
  output logic [4:0]  rf_saddr,
  output logic [4:0]  rf_sid,
  input  logic        cdb0_valid,
  input  logic [4:0]  cdb0_id,
  input  logic [31:0] cdb0_data,
  input  logic        cdb0_mispred,
  input  logic [31:0] cdb0_target,
  input  logic        cdb1_valid,
  input  logic [4:0]  cdb1_id,
  input  logic [31:0] cdb1_data,
  input  logic [4:0]  q1_id,
  input  logic [4:0]  q2_id,
  output logic        q1_ready,
  output logic [31:0] q1_data,
  output logic        q2_ready,
  output logic [31:0] q2_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [4:0]  rf_wid,
  output logic [31:0] rf_wdata,
  output logic        store_commit,
  output logic [4:0]  store_id,
  output logic        rst_c,
  output logic [31:0] jump_pc
);

  localparam int IW = $clog2(DEPTH);
  typedef logic [IW-1:0] idx_t;

  idx_t           head, tail;
  logic [IW:0]    count;
  logic [DEPTH-1:0] busy, ready, has_rd, is_store, mispred;
  logic [4:0]     rd     [DEPTH];
  logic [31:0]    data   [DEPTH];
  logic [31:0]    target [DEPTH];

  logic accept, commit_fire, flush_fire, wb_en, cdb0_hit, cdb1_hit;
  logic [32:0] q1_res, q2_res;

  function automatic logic in_range(input logic [4:0] id);
    return 32'(id) < 32'(DEPTH);
  endfunction

  function automatic idx_t to_idx(input logic [4:0] id);
    return id[IW-1:0];
  endfunction

  function automatic logic [4:0] to_id(input idx_t i);
    return 5'(i);
  endfunction

  // Operand bypass: a latched result beats the buses, cdb0 beats cdb1.
  function automatic logic [32:0] lookup(input logic [4:0] qid);
    logic [32:0] r;
    r = '0;
    if (in_range(qid) && busy[to_idx(qid)] && ready[to_idx(qid)])
      r = {1'b1, data[to_idx(qid)]};
    else if (cdb0_valid && cdb0_id == qid)
      r = {1'b1, cdb0_data};
    else if (cdb1_valid && cdb1_id == qid)
      r = {1'b1, cdb1_data};
    return r;
  endfunction

  assign rob_full    = (count == (IW+1)'(DEPTH));
  assign accept      = rst && alloc_valid && !rob_full && !rst_c && rdy;
  assign commit_fire = rdy && (count != '0) && busy[head] && ready[head];
  assign flush_fire  = commit_fire && mispred[head];
  assign wb_en       = rdy && !rst_c;
  assign cdb0_hit    = wb_en && cdb0_valid && in_range(cdb0_id) && busy[to_idx(cdb0_id)];
  assign cdb1_hit    = wb_en && cdb1_valid && in_range(cdb1_id) && busy[to_idx(cdb1_id)];

  assign alloc_id = to_id(tail);
  assign rf_se    = accept && alloc_has_rd;
  assign rf_saddr = rf_se ? alloc_rd : 5'd0;
  assign rf_sid   = rf_se ? to_id(tail) : 5'd0;

  always_comb begin
    q1_res   = lookup(q1_id);
    q2_res   = lookup(q2_id);
    q1_ready = q1_res[32];
    q1_data  = q1_res[31:0];
    q2_ready = q2_res[32];
    q2_data  = q2_res[31:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      busy         <= '0;
      ready        <= '0;
      has_rd       <= '0;
      is_store     <= '0;
      mispred      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd[i]     <= '0;
        data[i]   <= '0;
        target[i] <= '0;
      end
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wid       <= '0;
      rf_wdata     <= '0;
      store_commit <= 1'b0;
      store_id     <= '0;
      rst_c        <= 1'b0;
      jump_pc      <= '0;
    end else if (rdy) begin
      rf_we        <= commit_fire && has_rd[head];
      store_commit <= commit_fire && is_store[head];
      rst_c        <= flush_fire;
      if (commit_fire) begin
        rf_waddr <= rd[head];
        rf_wid   <= to_id(head);
        rf_wdata <= data[head];
        store_id <= to_id(head);
      end
      if (flush_fire) jump_pc <= target[head];

      // A flush discards everything younger, including this cycle's alloc/writebacks.
      if (flush_fire) begin
        busy  <= '0;
        ready <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (cdb1_hit) begin
          ready[to_idx(cdb1_id)]   <= 1'b1;
          data[to_idx(cdb1_id)]    <= cdb1_data;
          mispred[to_idx(cdb1_id)] <= 1'b0;
          target[to_idx(cdb1_id)]  <= '0;
        end
        if (cdb0_hit) begin
          ready[to_idx(cdb0_id)]   <= 1'b1;
          data[to_idx(cdb0_id)]    <= cdb0_data;
          mispred[to_idx(cdb0_id)] <= cdb0_mispred;
          target[to_idx(cdb0_id)]  <= cdb0_target;
        end
        if (accept) begin
          busy[tail]     <= 1'b1;
          ready[tail]    <= 1'b0;
          has_rd[tail]   <= alloc_has_rd;
          rd[tail]       <= alloc_rd;
          is_store[tail] <= alloc_is_store;
          mispred[tail]  <= 1'b0;
          tail           <= tail + idx_t'(1);
        end
        if (commit_fire) begin
          busy[head]  <= 1'b0;
          ready[head] <= 1'b0;
          head        <= head + idx_t'(1);
        end
        if (accept && !commit_fire)
          count <= count + (IW+1)'(1);
        else if (!accept && commit_fire)
          count <= count - (IW+1)'(1);
      end
    end
  end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Reorder buffer between dispatch/execute and the register file.
- Allocates in-order entries at dispatch and drives the regfile rename-tag port (se/saddr/sid).
- Captures out-of-order results from two common data buses. Retires one entry per cycle in order through the regfile write port (we/waddr/wid/wdata).
- A committing mispredicted branch raises the global flush (rst_c) and a redirect PC.

Parameters:
- DEPTH, 16, number of entries; power of two, 2..32; entry index is zero-extended onto the 5-bit id buses.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-low
- rdy  input  1  global enable; 0 freezes all state and outputs
- alloc_valid  input  1  dispatch requests an entry this cycle
- alloc_has_rd  input  1  instruction writes rd
- alloc_rd  input  5  destination register
- alloc_is_store  input  1  instruction is a store
- alloc_id  output  5  id granted to the current request (tail index)
- rob_full  output  1  count==DEPTH
- rf_se, rf_saddr, rf_sid  output  1/5/5  regfile tag set; combinational
- cdb0_valid, cdb0_id, cdb0_data  input  1/5/32  ALU result bus
- cdb0_mispred, cdb0_target  input  1/32  branch resolved mispredicted, correct PC
- cdb1_valid, cdb1_id, cdb1_data  input  1/5/32  load/store result bus; never mispredicts
- q1_id, q2_id  input  5  operand lookups for not-ready regfile tags
- q1_ready, q1_data, q2_ready, q2_data  output  1/32 each  lookup results; combinational
- rf_we, rf_waddr, rf_wid, rf_wdata  output  1/5/5/32  commit write to regfile; registered
- store_commit, store_id  output  1/5  releases committed store to LSB; registered
- rst_c  output  1  flush pulse; registered
- jump_pc  output  32  redirect target, valid while rst_c=1

Behaviour:
- Reset (rst=0, async):
  - head=tail=count=0 and all busy/ready bits cleared.
  - rf_we, store_commit and rst_c are 0; all data/id outputs are 0.
- Entry fields: busy, ready, has_rd, rd, is_store, data[31:0], mispred, target[31:0].
- Allocation:
  - accept = alloc_valid && !rob_full && !rst_c && rdy.
  - alloc_id = tail.
  - rf_se = accept && alloc_has_rd, with rf_saddr=alloc_rd and rf_sid=tail.
  - On the edge: the entry becomes busy with ready=0; tail=(tail+1) mod DEPTH.
  - A request while full is ignored; dispatch must hold it.
  - rob_full reflects the current count, so no alloc is accepted in a full cycle even if a commit happens in that cycle.
- Writeback:
  - On the edge, cdbN_valid && busy[cdbN_id] sets ready=1 and latches data, mispred and target.
  - If both buses name the same id, cdb0 wins.
  - A CDB write to a non-busy id is ignored.
  - Ready is sampled from registered state, so a result is never committed in its own writeback cycle.
- Lookup, per query, in priority order:
  - entry ready: stored data, ready=1;
  - else cdb0 matches: cdb0_data, ready=1;
  - else cdb1 matches: cdb1_data, ready=1;
  - else ready=0, data=0.
- Commit:
  - Occurs when count>0 && busy[head] && ready[head] && rdy. On that edge:
    - rf_we=has_rd, rf_waddr=rd, rf_wid=head, rf_wdata=data;
    - store_commit=is_store, store_id=head;
    - busy[head] cleared, head advances, count decrements.
  - Otherwise rf_we and store_commit go to 0 next cycle.
  - Latency: earliest commit output is 2 cycles after the CDB result edge (ready latched, then registered commit).
- Count: simultaneous accept and commit leaves count unchanged.
- Mispredict at commit (head entry has mispred=1):
  - Same edge: the commit write is still issued (jal/jalr rd), rst_c=1, jump_pc=target.
  - All busy bits are cleared and head=tail=count=0.
  - rst_c lasts exactly one cycle; during it, alloc and CDB inputs are ignored.
- Wrap-around: head and tail wrap mod DEPTH; ids equal their index.
- rdy=0: no register changes, including commit and flush outputs, which hold their value.
- Async reset mid-operation clears everything immediately, including a pending rst_c.

Test Plan:
- Reset, alloc three entries (rd=1,2,3 → ids 0,1,2, rf_se each cycle). CDB results in order id2=0x33, id0=0x11, id1=0x22 → rf_we pulses in order waddr 1/2/3 with data 0x11/0x22/0x33 on consecutive cycles.
- Alloc 16 with no results → rob_full=1 and a 17th alloc yields no rf_se. Complete id0 → one commit, rob_full=0, next alloc_id=0 (wrap).
- Alloc ids 0,1,2. cdb0 marks id0 mispred target 0x100 and completes ids 1,2 → one cycle of rst_c=1, jump_pc=0x100. Ids 1,2 never commit; the next alloc gets id 0.
- Entry 5 pending; q1_id=5 while cdb1 writes id5=0xABCD → q1_ready=1, q1_data=0xABCD that cycle. Next cycle the value comes from the entry.
- Store entry completes, then rdy=0 for 3 cycles → no commit and state frozen. After rdy=1, a single store_commit=1 with store_id=entry and rf_we=0.
- rst=0 asserted while count=4 and a commit is pending → outputs 0 immediately. After release, alloc_id=0 and rob_full=0.
